datapath_controller: RTL

Sequencing controller that drives the control inputs of the team's register-file/ALU datapath. It latches one 16-bit instruction on a start/ready handshake, decodes it, and steps a Moore state machine that issues the register reads, A/B/C/status loads, ALU/shift selects and register write-back the datapath needs, one datapath micro-step per cycle. It sits between the instruction source (bench or fetch unit) and the datapath's control and `datapath_in` ports.

---
 rtl/datapath_controller.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/datapath_controller.sv
// datapath_controller
// Moore sequencer for the register-file/ALU datapath. Captures one 16-bit
// instruction on the s/w handshake, decodes it and steps the datapath through
// register reads, ALU evaluation and write-back, one micro-step per cycle.
// Optional feature macro: DPCTRL_BAD_INSTR_EN -- when defined, an undefined
// encoding pulses bad_instr for its DECODE cycle; otherwise bad_instr is 0.
module datapath_controller #(
    parameter int data_width = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s,
    input  logic [15:0]           instr,
    output logic                  w,
    output logic                  bad_instr,
    output logic [2:0]            writenum,
    output logic [2:0]            readnum,
    output logic [2:0]            ALUop,
    output logic [2:0]            shift,
    output logic                  write,
    output logic                  loada,
    output logic                  loadb,
    output logic                  loadc,
    output logic                  loads,
    output logic                  asel,
    output logic                  bsel,
    output logic                  vsel,
    output logic [data_width-1:0] datapath_in
);

    typedef enum logic [2:0] {
        WAIT      = 3'd0,
        DECODE    = 3'd1,
        GET_A     = 3'd2,
        GET_B     = 3'd3,
        ALU       = 3'd4,
        WRITE_REG = 3'd5,
        WRITE_IMM = 3'd6
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_NOT = 3'b011;

    state_t      state;
    state_t      next_state;
    logic [15:0] ir;

    // Instruction fields, all taken from the latched IR so outputs stay Moore.
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;
    logic [7:0] imm8;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign imm8   = ir[7:0];

    logic is_mov_imm;
    logic is_mov_reg;
    logic is_add;
    logic is_cmp;
    logic is_and;
    logic is_mvn;

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_add     = (opcode == 3'b101) && (op == 2'b00);
    assign is_cmp     = (opcode == 3'b101) && (op == 2'b01);
    assign is_and     = (opcode == 3'b101) && (op == 2'b10);
    assign is_mvn     = (opcode == 3'b101) && (op == 2'b11);

    // Sign-extend the 8-bit immediate to the datapath width.
    function automatic logic [data_width-1:0] sext_imm8(input logic [7:0] v);
        logic signed [7:0] sv;
        sv = signed'(v);
        return data_width'(sv);
    endfunction

    assign datapath_in = sext_imm8(imm8);

`ifdef DPCTRL_BAD_INSTR_EN
    assign bad_instr = (state == DECODE) && !(is_mov_imm || is_mov_reg || is_add ||
                                              is_cmp || is_and || is_mvn);
`else
    assign bad_instr = 1'b0;
`endif

    // State register and instruction latch; reset aborts any sequence at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= WAIT;
            ir    <= 16'h0000;
        end else begin
            state <= next_state;
            if ((state == WAIT) && s) begin
                ir <= instr;
            end
        end
    end

    // Next-state decode and per-state control outputs (Moore).
    always_comb begin
        next_state = state;
        w          = 1'b0;
        writenum   = 3'd0;
        readnum    = 3'd0;
        ALUop      = ALU_ADD;
        shift      = 3'd0;
        write      = 1'b0;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        vsel       = 1'b0;
        case (state)
            WAIT: begin
                w = 1'b1;
                if (s) begin
                    next_state = DECODE;
                end
            end
            DECODE: begin
                if (is_mov_imm) begin
                    next_state = WRITE_IMM;
                end else if (is_add || is_and || is_cmp) begin
                    next_state = GET_A;
                end else if (is_mov_reg || is_mvn) begin
                    next_state = GET_B;
                end else begin
                    next_state = WAIT;
                end
            end
            GET_A: begin
                readnum    = rn;
                loada      = 1'b1;
                next_state = GET_B;
            end
            GET_B: begin
                readnum    = rm;
                loadb      = 1'b1;
                next_state = ALU;
            end
            ALU: begin
                shift = {1'b0, sh};
                // Single-operand ops zero the A input so B passes through.
                asel  = is_mov_reg || is_mvn;
                if (is_cmp) begin
                    ALUop = ALU_SUB;
                end else if (is_and) begin
                    ALUop = ALU_AND;
                end else if (is_mvn) begin
                    ALUop = ALU_NOT;
                end else begin
                    ALUop = ALU_ADD;
                end
                if (is_cmp) begin
                    loads      = 1'b1;
                    next_state = WAIT;
                end else begin
                    loadc      = 1'b1;
                    next_state = WRITE_REG;
                end
            end
            WRITE_REG: begin
                writenum   = rd;
                write      = 1'b1;
                next_state = WAIT;
            end
            WRITE_IMM: begin
                writenum   = rn;
                vsel       = 1'b1;
                write      = 1'b1;
                next_state = WAIT;
            end
            default: begin
                next_state = WAIT;
            end
        endcase
    end

endmodule
